fp_cmp_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one `fp_cmp` instance among `NUM_REQ` requesters, such as scalar issue lanes or a min/max unit. Each requester presents an operand pair and a compare opcode through a valid/ready handshake. The block grants one requester at a time, drives the comparator from registered operands, and returns a single-bit result, the requester ID and the exception flags through a valid/ready response port.

---
 rtl/fp_pkg.sv | 54 +++++
 rtl/fp_cmp.sv | 50 +++++
 rtl/fp_cmp_arb.sv | 130 +++++++++++++
 tb/tb_fp_cmp_arb.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point types: formats, exception flags, compare opcodes and
// the arbiter FSM encoding used by the compare sequencer.
package fp_pkg;

  typedef enum logic [1:0] {
    FP32 = 2'd0,
    FP64 = 2'd1,
    FP16 = 2'd2,
    BF16 = 2'd3
  } fp_format_e;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;

  typedef enum logic [1:0] {
    CMP_LT  = 2'b00,
    CMP_LE  = 2'b01,
    CMP_EQ  = 2'b10,
    CMP_RSV = 2'b11
  } cmp_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  function automatic int unsigned fp_width(input fp_format_e fmt);
    case (fmt)
      FP64:    return 64;
      FP16:    return 16;
      BF16:    return 16;
      default: return 32;
    endcase
  endfunction

  function automatic int unsigned fp_exp_bits(input fp_format_e fmt);
    case (fmt)
      FP64:    return 11;
      FP16:    return 5;
      default: return 8;
    endcase
  endfunction

  function automatic int unsigned fp_man_bits(input fp_format_e fmt);
    return fp_width(fmt) - fp_exp_bits(fmt) - 1;
  endfunction

endpackage

// File: rtl/fp_cmp.sv
// Single-cycle IEEE-754 comparator. eq_en_i selects a quiet compare (only
// signalling NaNs raise NV); otherwise any NaN raises NV.
module fp_cmp
  import fp_pkg::*;
#(
  parameter fp_format_e FP_FORMAT = FP32,
  localparam int unsigned W = fp_width(FP_FORMAT),
  localparam int unsigned E = fp_exp_bits(FP_FORMAT),
  localparam int unsigned M = fp_man_bits(FP_FORMAT)
) (
  input  logic         start_i,
  input  logic         eq_en_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         lt_o,
  output logic         le_o,
  output logic         eq_o,
  output status_t      flags_o,
  output logic         done_o
);

  logic a_nan, b_nan, a_snan, b_snan, any_nan;
  logic both_zero, mag_lt, mag_eq, lt_raw, eq_raw;

  always_comb begin
    a_nan     = (&a_i[W-2 -: E]) & (|a_i[M-1:0]);
    b_nan     = (&b_i[W-2 -: E]) & (|b_i[M-1:0]);
    a_snan    = a_nan & ~a_i[M-1];
    b_snan    = b_nan & ~b_i[M-1];
    any_nan   = a_nan | b_nan;
    both_zero = ~(|a_i[W-2:0]) & ~(|b_i[W-2:0]);
    mag_lt    = a_i[W-2:0] < b_i[W-2:0];
    mag_eq    = a_i[W-2:0] == b_i[W-2:0];
    eq_raw    = both_zero | (a_i == b_i);

    // Sign-magnitude ordering; +0 and -0 are equal.
    if (both_zero)                lt_raw = 1'b0;
    else if (a_i[W-1] != b_i[W-1]) lt_raw = a_i[W-1];
    else if (!a_i[W-1])           lt_raw = mag_lt;
    else                          lt_raw = ~mag_lt & ~mag_eq;

    lt_o       = start_i & ~any_nan & lt_raw;
    eq_o       = start_i & ~any_nan & eq_raw;
    le_o       = start_i & ~any_nan & (lt_raw | eq_raw);
    flags_o    = '0;
    flags_o.nv = start_i & (eq_en_i ? (a_snan | b_snan) : any_nan);
    done_o     = start_i;
  end

endmodule

// File: rtl/fp_cmp_arb.sv
// Round-robin arbiter that time-shares one fp_cmp among NUM_REQ requesters
// and returns result, requester id and flags on a registered response port.
module fp_cmp_arb
  import fp_pkg::*;
#(
  parameter fp_format_e  FP_FORMAT = FP32,
  parameter int unsigned NUM_REQ   = 4,
  localparam int unsigned FP_WIDTH = fp_width(FP_FORMAT),
  localparam int unsigned ID_W     = $clog2(NUM_REQ)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NUM_REQ-1:0]                 req_valid_i,
  output logic [NUM_REQ-1:0]                 req_ready_o,
  input  logic [NUM_REQ-1:0][FP_WIDTH-1:0]   req_a_i,
  input  logic [NUM_REQ-1:0][FP_WIDTH-1:0]   req_b_i,
  input  logic [NUM_REQ-1:0][1:0]            req_op_i,
  output logic                               rsp_valid_o,
  input  logic                               rsp_ready_i,
  output logic [ID_W-1:0]                    rsp_id_o,
  output logic                               rsp_result_o,
  output status_t                            rsp_flags_o,
  output logic                               rsp_err_o,
  output arb_state_e                         dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and the response holds until taken.

  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                            input logic [ID_W-1:0]    ptr);
    logic              found;
    logic [ID_W-1:0]   idx;
    int unsigned       j;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = (32'(ptr) + k) % NUM_REQ;
      if (!found && valid[j]) begin
        found = 1'b1;
        idx   = ID_W'(j);
      end
    end
    return {found, idx};
  endfunction

  arb_state_e          state_q, state_d;
  logic [ID_W-1:0]     ptr_q, win_idx, id_q;
  logic                win_found, accept;
  logic [FP_WIDTH-1:0] a_q, b_q;
  cmp_op_e             op_q;
  logic                cmp_start, cmp_eq_en, cmp_lt, cmp_le, cmp_eq, cmp_done;
  status_t             cmp_flags;

  assign {win_found, win_idx} = rr_pick(req_valid_i, ptr_q);
  assign accept      = (state_q == IDLE) && win_found;
  assign dbg_state_o = state_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_found)   state_d = EXEC;
      EXEC:    if (cmp_done)    state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = '0;
    if (accept) req_ready_o[win_idx] = 1'b1;
    cmp_start = (state_q == EXEC);
    cmp_eq_en = (op_q == CMP_EQ);
  end

  fp_cmp #(.FP_FORMAT(FP_FORMAT)) u_fp_cmp (
    .start_i (cmp_start),
    .eq_en_i (cmp_eq_en),
    .a_i     (a_q),
    .b_i     (b_q),
    .lt_o    (cmp_lt),
    .le_o    (cmp_le),
    .eq_o    (cmp_eq),
    .flags_o (cmp_flags),
    .done_o  (cmp_done)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= CMP_LT;
      id_q         <= '0;
      rsp_valid_o  <= 1'b0;
      rsp_id_o     <= '0;
      rsp_result_o <= 1'b0;
      rsp_flags_o  <= '0;
      rsp_err_o    <= 1'b0;
    end else begin
      if (accept) begin
        a_q   <= req_a_i[win_idx];
        b_q   <= req_b_i[win_idx];
        op_q  <= cmp_op_e'(req_op_i[win_idx]);
        id_q  <= win_idx;
        ptr_q <= (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
      end
      if (state_q == EXEC && cmp_done) begin
        rsp_valid_o <= 1'b1;
        rsp_id_o    <= id_q;
        rsp_err_o   <= (op_q == CMP_RSV);
        rsp_flags_o <= (op_q == CMP_RSV) ? '0 : cmp_flags;
        case (op_q)
          CMP_LT:  rsp_result_o <= cmp_lt;
          CMP_LE:  rsp_result_o <= cmp_le;
          CMP_EQ:  rsp_result_o <= cmp_eq;
          default: rsp_result_o <= 1'b0;
        endcase
      end else if (state_q == RESP && rsp_ready_i) begin
        rsp_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fp_cmp_arb.sv
// Self-checking bench for fp_cmp_arb: directed compares, round-robin order,
// backpressure, reset mid-response, and randomized compares against a model.
module tb_fp_cmp_arb;
  import fp_pkg::*;

  localparam int N = 4;
  localparam logic [31:0] ONE  = 32'h3F800000;
  localparam logic [31:0] TWO  = 32'h40000000;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [31:0] SNAN = 32'h7FA00000;
  localparam logic [4:0]  NV   = 5'b10000;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         req_valid;
  logic [N-1:0]         req_ready;
  logic [N-1:0][31:0]   req_a, req_b;
  logic [N-1:0][1:0]    req_op;
  logic                 rsp_valid, rsp_ready, rsp_result, rsp_err;
  logic [1:0]           rsp_id;
  status_t              rsp_flags;
  arb_state_e           dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // expected entry: {id[1:0], result, err, flags[4:0]}
  logic [8:0] exp_q[$];
  int         acc_q[$];
  bit         prev_valid = 1'b0;
  bit         rr_mode = 1'b0;
  int         rr_seen = 0;
  int         last_hs = 0;

  fp_cmp_arb #(.FP_FORMAT(FP32), .NUM_REQ(N)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .req_op_i     (req_op),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_id_o     (rsp_id),
    .rsp_result_o (rsp_result),
    .rsp_flags_o  (rsp_flags),
    .rsp_err_o    (rsp_err),
    .dbg_state_o  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // reference compare: map each operand onto a signed integer line
  function automatic longint fkey(input logic [31:0] x);
    longint m;
    m = longint'(x[30:0]);
    if (m == 0) return 0;
    return x[31] ? -m : m;
  endfunction

  function automatic logic [6:0] model(input logic [31:0] a, input logic [31:0] b,
                                       input logic [1:0] op);
    bit na, nb, sa, sb, res;
    logic [4:0] fl;
    if (op == 2'b11) return {1'b0, 1'b1, 5'b0};
    na = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    nb = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    sa = na && !a[22];
    sb = nb && !b[22];
    fl = 5'b0;
    if (na || nb) begin
      res = 1'b0;
      if (op == 2'b10) fl = (sa || sb) ? NV : 5'b0;
      else             fl = NV;
    end else begin
      case (op)
        2'b00:   res = fkey(a) <  fkey(b);
        2'b01:   res = fkey(a) <= fkey(b);
        default: res = fkey(a) == fkey(b);
      endcase
    end
    return {res, 1'b0, fl};
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 11))
      0:       return 32'h00000000;
      1:       return 32'h80000000;
      2:       return ONE;
      3:       return 32'hBF800000;
      4:       return TWO;
      5:       return 32'hC0000000;
      6:       return 32'h7F800000;
      7:       return 32'hFF800000;
      8:       return QNAN;
      9:       return SNAN;
      10:      return 32'h00000001;
      default: return $urandom();
    endcase
  endfunction

  // scoreboard / monitor
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (rsp_valid && !prev_valid) begin
        check("acc_pending", 32'(acc_q.size() > 0), 1);
        if (acc_q.size() > 0) check("latency", cyc - acc_q.pop_front(), 2);
      end
      if (rsp_valid && rsp_ready) begin
        logic [8:0] e;
        check("rsp_pending", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("rsp_id", rsp_id, e[8:7]);
          check("rsp_result", rsp_result, e[6]);
          check("rsp_err", rsp_err, e[5]);
          check("rsp_flags", rsp_flags, e[4:0]);
        end
        if (rr_mode) begin
          if (rr_seen > 0) check("rr_spacing", cyc - last_hs, 3);
          rr_seen++;
        end
        last_hs = cyc;
      end
      prev_valid = rsp_valid;
    end
  end

  // driver tasks
  task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op);
    req_a[r]  = a;
    req_b[r]  = b;
    req_op[r] = op;
  endtask

  task automatic send(input int r, input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] op, input logic res, input logic err,
                      input logic [4:0] fl);
    bit granted;
    logic [1:0] rid;
    rid = r[1:0];
    @(posedge clk); #1;
    set_req(r, a, b, op);
    req_valid[r] = 1'b1;
    granted = 1'b0;
    for (int k = 0; k < 50 && !granted; k++) begin
      @(negedge clk);
      if (req_ready[r]) granted = 1'b1;
    end
    check("grant_wait", 32'(granted), 1);
    if (granted) begin
      exp_q.push_back({rid, res, err, fl});
      acc_q.push_back(cyc);
    end
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic wait_drain();
    bit idle;
    idle = 1'b0;
    for (int k = 0; k < 200 && !idle; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && dbg_state == IDLE) idle = 1'b1;
    end
    check("drain", 32'(idle), 1);
  endtask

  // main sequence
  initial begin
    int accepts;
    logic [1:0] rr_ids[5];
    logic [6:0] m;
    logic [31:0] ra, rb;
    logic [1:0]  rop;
    int rr;

    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_valid", rsp_valid, 0);
    check("rst_id", rsp_id, 0);
    check("rst_result", rsp_result, 0);
    check("rst_err", rsp_err, 0);
    check("rst_flags", rsp_flags, 0);
    check("rst_ready", req_ready, 0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));

    // round robin: all four valid, served 0,1,2,3,0, one every 3 cycles
    set_req(0, ONE, TWO, 2'b00);
    set_req(1, ONE, TWO, 2'b01);
    set_req(2, ONE, TWO, 2'b10);
    set_req(3, TWO, ONE, 2'b00);
    rr_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_q.push_back({2'd0, 1'b1, 1'b0, 5'b0});
    exp_q.push_back({2'd1, 1'b1, 1'b0, 5'b0});
    exp_q.push_back({2'd2, 1'b0, 1'b0, 5'b0});
    exp_q.push_back({2'd3, 1'b0, 1'b0, 5'b0});
    exp_q.push_back({2'd0, 1'b1, 1'b0, 5'b0});
    rr_mode = 1'b1;
    rr_seen = 0;
    @(posedge clk); #1;
    req_valid = 4'hF;
    accepts = 0;
    for (int k = 0; k < 60 && accepts < 5; k++) begin
      @(negedge clk);
      if (|(req_valid & req_ready)) begin
        check("rr_grant", req_ready, 32'(4'b0001 << rr_ids[accepts]));
        acc_q.push_back(cyc);
        accepts++;
        if (accepts == 5) begin
          @(posedge clk); #1;
          req_valid = '0;
        end
      end
    end
    check("rr_accepts", accepts, 5);
    wait_drain();
    rr_mode = 1'b0;

    // directed compares
    send(0, ONE, TWO, 2'b00, 1'b1, 1'b0, 5'b0);
    send(2, QNAN, ONE, 2'b10, 1'b0, 1'b0, 5'b0);
    send(2, QNAN, ONE, 2'b01, 1'b0, 1'b0, NV);
    send(2, SNAN, 32'h0, 2'b10, 1'b0, 1'b0, NV);
    send(0, 32'h80000000, 32'h00000000, 2'b10, 1'b1, 1'b0, 5'b0);
    send(0, 32'h80000000, 32'h00000000, 2'b00, 1'b0, 1'b0, 5'b0);
    send(1, SNAN, SNAN, 2'b11, 1'b0, 1'b1, 5'b0);
    send(3, 32'hC0000000, 32'hBF800000, 2'b00, 1'b1, 1'b0, 5'b0);
    send(3, 32'h7F800000, 32'h7F800000, 2'b01, 1'b1, 1'b0, 5'b0);
    wait_drain();

    // randomized compares against the reference model
    for (int t = 0; t < 24; t++) begin
      rr  = $urandom_range(0, N - 1);
      ra  = pick_val();
      rb  = ($urandom_range(0, 3) == 0) ? ra : pick_val();
      rop = 2'($urandom_range(0, 3));
      m   = model(ra, rb, rop);
      send(rr, ra, rb, rop, m[6], m[5], m[4:0]);
    end
    wait_drain();

    // backpressure: response held, no grants, then reset mid-response
    rsp_ready = 1'b0;
    send(1, ONE, TWO, 2'b00, 1'b1, 1'b0, 5'b0);
    for (int k = 0; k < 10 && !rsp_valid; k++) @(negedge clk);
    check("bp_arrived", rsp_valid, 1);
    @(posedge clk); #1;
    set_req(3, TWO, ONE, 2'b00);
    req_valid = 4'b1010;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid", rsp_valid, 1);
      check("bp_id", rsp_id, 1);
      check("bp_result", rsp_result, 1);
      check("bp_ready", req_ready, 0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    check("post_rst_valid", rsp_valid, 0);
    check("post_rst_state", 32'(dbg_state), 32'(IDLE));
    check("post_rst_grant", req_ready, 32'(4'b0010));
    if (req_ready[1]) begin
      exp_q.push_back({2'd1, 1'b1, 1'b0, 5'b0});
      acc_q.push_back(cyc);
    end
    @(posedge clk); #1;
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
